dsm_target_sequencer: RTL and testbench

- Controller in front of the 4-stage MASH modulator datapath. Owns the 32-bit `target` word that feeds the modulator.
- Accepts new target requests over a valid/ready handshake and slews the applied target toward the request in programmable steps at a prescaled tick rate.
- Waits out the modulator pipeline latency, then signals completion.
- Prevents step discontinuities in the modulator input.

---
 rtl/dsm_target_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_dsm_target_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dsm_target_sequencer.sv
// dsm_target_sequencer
// Owns the 32-bit target word feeding the MASH modulator. New goals arrive
// over a valid/ready handshake. The applied target slews toward the goal in
// clamped steps at a prescaled tick rate. After the goal is reached, the block
// waits out the modulator pipeline latency and pulses done.
// Optional build macro: DSM_SEQ_MUTE_EN adds a mute input. Mute forces the
// target to midscale and freezes the sequencer.
module dsm_target_sequencer #(
    parameter logic [31:0] INIT_TARGET = 32'h8000_0000,
    parameter int          SETTLE_CYC  = 4,
    parameter int          DIV_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DSM_SEQ_MUTE_EN
    input  logic             mute,
`endif
    input  logic [31:0]      req_target,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      step,
    input  logic [DIV_W-1:0] div,
    output logic [31:0]      target,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAMP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic [1:0]       state_q,   state_d;
    logic [31:0]      target_q,  target_d;
    logic [31:0]      goal_q,    goal_d;
    logic [31:0]      step_q,    step_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [DIV_W-1:0] presc_q,   presc_d;
    logic [SET_W-1:0] settle_q,  settle_d;
    logic             ready_q,   ready_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             mute_s;
    logic [31:0]      dist_s;
    logic [31:0]      slew_s;

`ifdef DSM_SEQ_MUTE_EN
    assign mute_s = mute;
`else
    assign mute_s = 1'b0;
`endif

    // Next target one step toward the goal, clamped so it never overshoots or wraps.
    always_comb begin
        dist_s = 32'd0;
        slew_s = goal_q;
        if (goal_q >= target_q) begin
            dist_s = goal_q - target_q;
            if ((step_q == 32'd0) || (dist_s <= step_q)) begin
                slew_s = goal_q;
            end else begin
                slew_s = target_q + step_q;
            end
        end else begin
            dist_s = target_q - goal_q;
            if ((step_q == 32'd0) || (dist_s <= step_q)) begin
                slew_s = goal_q;
            end else begin
                slew_s = target_q - step_q;
            end
        end
    end

    // Sequencer state machine: handshake, ramp ticks, settle countdown.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        goal_d   = goal_q;
        step_d   = step_q;
        div_d    = div_q;
        presc_d  = presc_q;
        settle_d = settle_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (mute_s) begin
            // Everything holds except the target, which is parked at midscale.
            // Any in-progress settle restarts after release because the
            // target it was settling on has been disturbed.
            target_d = INIT_TARGET;
            ready_d  = 1'b0;
            settle_d = {SET_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        goal_d  = req_target;
                        step_d  = {16'd0, step};
                        div_d   = div;
                        presc_d = {DIV_W{1'b0}};
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        if (req_target == target_q) begin
                            state_d  = ST_SETTLE;
                            settle_d = {SET_W{1'b0}};
                        end else begin
                            state_d  = ST_RAMP;
                        end
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                ST_RAMP: begin
                    ready_d = 1'b0;
                    if (presc_q == div_q) begin
                        presc_d  = {DIV_W{1'b0}};
                        target_d = slew_s;
                        if (slew_s == goal_q) begin
                            state_d  = ST_SETTLE;
                            settle_d = {SET_W{1'b0}};
                        end else begin
                            state_d  = ST_RAMP;
                        end
                    end else begin
                        presc_d = presc_q + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_IDLE;
                        settle_d = {SET_W{1'b0}};
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                    end else begin
                        settle_d = settle_q + {{(SET_W-1){1'b0}}, 1'b1};
                        ready_d  = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    target_d = INIT_TARGET;
                    ready_d  = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= INIT_TARGET;
            goal_q   <= 32'd0;
            step_q   <= 32'd0;
            div_q    <= {DIV_W{1'b0}};
            presc_q  <= {DIV_W{1'b0}};
            settle_q <= {SET_W{1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            goal_q   <= goal_d;
            step_q   <= step_d;
            div_q    <= div_d;
            presc_q  <= presc_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign target    = target_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dsm_target_sequencer.sv
// Directed bench for dsm_target_sequencer with hand-computed expectations.
module tb_dsm_target_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_target;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] step;
    logic [7:0]  div;
    logic [31:0] target;
    logic        busy;
    logic        done;
`ifdef DSM_SEQ_MUTE_EN
    logic        mute;
`endif

    int checks   = 0;
    int failures = 0;

    dsm_target_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DSM_SEQ_MUTE_EN
        .mute       (mute),
`endif
        .req_target (req_target),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .step       (step),
        .div        (div),
        .target     (target),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done pulses (bounded) and check how many edges it took.
    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_target = 32'd0;
        req_valid  = 1'b0;
        step       = 16'd0;
        div        = 8'd0;
`ifdef DSM_SEQ_MUTE_EN
        mute       = 1'b0;
`endif
        tick();
        tick();
        // 1. reset state
        check_eq("rst_target", target, 32'h8000_0000);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_rel", 32'(req_ready), 32'd1);

        // 2. upward ramp, step 4, tick every 2 clocks
        req_target = 32'h8000_0010;
        step       = 16'd4;
        div        = 8'd1;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("up_accept_ready", 32'(req_ready), 32'd0);
        check_eq("up_accept_busy", 32'(busy), 32'd1);
        check_eq("up_accept_target", target, 32'h8000_0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("up_hold", target, 32'h8000_0000 + 32'(4 * (k - 1)));
            tick();
            check_eq("up_step", target, 32'h8000_0000 + 32'(4 * k));
        end
        wait_done("up_settle_len", 4);
        check_eq("up_done_busy", 32'(busy), 32'd0);
        check_eq("up_done_ready", 32'(req_ready), 32'd1);
        tick();
        check_eq("up_done_once", 32'(done), 32'd0);

        // step 0: single jump to 0x0000_000A on first tick
        req_target = 32'h0000_000A;
        step       = 16'd0;
        div        = 8'd0;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("jump_target", target, 32'h0000_000A);
        wait_done("jump_settle_len", 4);

        // 3. downward clamp to 0 without wrap
        req_target = 32'd0;
        step       = 16'd4;
        div        = 8'd0;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("down_6", target, 32'h0000_0006);
        tick();
        check_eq("down_2", target, 32'h0000_0002);
        tick();
        check_eq("down_0", target, 32'h0000_0000);
        wait_done("down_settle_len", 4);
        check_eq("down_final", target, 32'h0000_0000);

        // 4. equal goal: settle only. Next request held valid across done.
        req_target = 32'd0;
        step       = 16'd7;
        div        = 8'd3;
        req_valid  = 1'b1;
        tick();
        check_eq("eq_busy", 32'(busy), 32'd1);
        req_target = 32'h0000_1000;
        step       = 16'd1;
        div        = 8'd0;
        wait_done("eq_settle_len", 4);
        check_eq("eq_target", target, 32'h0000_0000);
        check_eq("eq_not_taken_busy", 32'(busy), 32'd0);
        tick();
        check_eq("next_cycle_accept", 32'(busy), 32'd1);
        check_eq("next_cycle_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("ramp1", target, 32'h0000_0001);
        tick();
        check_eq("ramp2", target, 32'h0000_0002);

        // 5. reset mid-ramp with req_valid still high
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_target", target, 32'h8000_0000);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        tick();
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_not_taken", 32'(busy), 32'd0);
        check_eq("rel_ready", 32'(req_ready), 32'd1);
        check_eq("rel_no_done", 32'(done), 32'd0);
        tick();
        check_eq("rel_taken", 32'(busy), 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef DSM_SEQ_MUTE_EN
        // 6. mute mid-ramp freezes the sequencer, ramp resumes from midscale
        req_target = 32'h8000_0040;
        step       = 16'd8;
        div        = 8'd0;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("mute_pre1", target, 32'h8000_0008);
        tick();
        check_eq("mute_pre2", target, 32'h8000_0010);
        mute = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("mute_target", target, 32'h8000_0000);
            check_eq("mute_busy", 32'(busy), 32'd1);
        end
        mute = 1'b0;
        tick();
        check_eq("mute_resume", target, 32'h8000_0008);
        wait_done("mute_finish_len", 11);
        check_eq("mute_goal", target, 32'h8000_0040);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
